// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flush, data-memory freeze,
// plus a saturating stall-cycle counter for performance debug.
module hazard_stall_ctrl #(
    parameter int REG_AW       = 4,
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_hold,
    output logic              if_id_write,
    output logic              if_flush,
    output logic              id_ex_hold,
    output logic              id_ex_bubble,
    output logic              ex_mem_hold,
    output logic [1:0]        ctrl_state,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam logic [2:0] LS_REM = 3'(LOAD_STALL - 1);
    localparam logic [2:0] FL_REM = 3'(FLUSH_CYCLES);

    state_t     state, nxt_state, ret, nxt_ret, eff;
    logic [2:0] rem, nxt_rem;
    logic       hazard;

    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    // After a freeze, the cycle acts as the state we were frozen in
    assign eff = (state == MEM_WAIT) ? ret : state;

    assign ctrl_state = state;

    // State, remaining count, return state
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            rem   <= 3'd0;
            ret   <= RUN;
        end else begin
            state <= nxt_state;
            rem   <= nxt_rem;
            ret   <= nxt_ret;
        end
    end

    // Next-state and same-cycle pipeline controls
    always_comb begin
        pc_hold      = 1'b0;
        if_id_write  = 1'b0;
        if_flush     = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        nxt_state    = state;
        nxt_rem      = rem;
        nxt_ret      = ret;
        if (reset) begin
            pc_hold      = 1'b1;
            if_flush     = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_hold     = 1'b1;
            if_id_write = 1'b1;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
            if (state != MEM_WAIT) begin
                nxt_ret   = state;
                nxt_state = MEM_WAIT;
            end
        end else begin
            nxt_state = eff;
            if (branch_taken) begin
                // Branch wins in every non-frozen state; pending stall is dropped
                if_flush     = 1'b1;
                id_ex_bubble = 1'b1;
                nxt_rem      = FL_REM;
                nxt_state    = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
            end else begin
                case (eff)
                    RUN: begin
                        if (hazard) begin
                            pc_hold      = 1'b1;
                            if_id_write  = 1'b1;
                            id_ex_bubble = 1'b1;
                            nxt_rem      = LS_REM;
                            nxt_state    = (LOAD_STALL == 1) ? RUN : LD_STALL;
                        end
                    end
                    LD_STALL: begin
                        pc_hold      = 1'b1;
                        if_id_write  = 1'b1;
                        id_ex_bubble = 1'b1;
                        nxt_rem      = rem - 3'd1;
                        if (rem == 3'd1) nxt_state = RUN;
                    end
                    FLUSH: begin
                        if_flush     = 1'b1;
                        id_ex_bubble = 1'b1;
                        nxt_rem      = rem - 3'd1;
                        if (rem == 3'd1) nxt_state = RUN;
                    end
                    default: nxt_state = RUN;
                endcase
            end
        end
    end

    // Saturating count of non-reset cycles with the PC held
    always_ff @(posedge clock) begin
        if (reset)
            stall_cnt <= 16'd0;
        else if (pc_hold && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: two instances share inputs; A uses LOAD_STALL=1, B uses LOAD_STALL=2.
module tb_hazard_stall_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_mem_read, branch_taken, mem_busy;

    logic       pc_a, ifid_a, fl_a, idh_a, bub_a, exh_a;
    logic       pc_b, ifid_b, fl_b, idh_b, bub_b, exh_b;
    logic [1:0] st_a, st_b;
    logic [15:0] cnt_a, cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // control vector order: pc_hold, if_id_write, if_flush, id_ex_hold, id_ex_bubble, ex_mem_hold
    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_RST   = 6'b101010;
    localparam logic [5:0] C_STALL = 6'b110010;
    localparam logic [5:0] C_FLUSH = 6'b001010;
    localparam logic [5:0] C_FRZ   = 6'b110101;

    logic [5:0] ctl_a, ctl_b;
    assign ctl_a = {pc_a, ifid_a, fl_a, idh_a, bub_a, exh_a};
    assign ctl_b = {pc_b, ifid_b, fl_b, idh_b, bub_b, exh_b};

    always #5 clock = ~clock;

    hazard_stall_ctrl #(.REG_AW(4), .LOAD_STALL(1), .FLUSH_CYCLES(1)) u_a (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_hold(pc_a), .if_id_write(ifid_a), .if_flush(fl_a), .id_ex_hold(idh_a),
        .id_ex_bubble(bub_a), .ex_mem_hold(exh_a), .ctrl_state(st_a), .stall_cnt(cnt_a));

    hazard_stall_ctrl #(.REG_AW(4), .LOAD_STALL(2), .FLUSH_CYCLES(1)) u_b (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_hold(pc_b), .if_id_write(ifid_b), .if_flush(fl_b), .id_ex_hold(idh_b),
        .id_ex_bubble(bub_b), .ex_mem_hold(exh_b), .ctrl_state(st_b), .stall_cnt(cnt_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // let combinational outputs settle after driving inputs
    task automatic settle();
        #2;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rt = 0;
        ex_mem_read = 0; branch_taken = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_hazard();
        ex_mem_read = 1; ex_rd = 4'd3; id_rs = 4'd3;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1;
        // 1. reset
        settle(); chk("rst_ctl0", 32'(ctl_a), 32'(C_RST));
        tick(); settle(); chk("rst_ctl1", 32'(ctl_a), 32'(C_RST));
        chk("rst_ctl1b", 32'(ctl_b), 32'(C_RST));
        tick(); reset = 1'b0; settle();
        chk("rel_state", 32'(st_a), 0);
        chk("rel_cnt", 32'(cnt_a), 0);
        chk("rel_ctl", 32'(ctl_a), 32'(C_NONE));

        // 2. single-cycle load-use stall (A)
        set_hazard(); settle();
        chk("ld_ctl", 32'(ctl_a), 32'(C_STALL));
        tick(); idle(); settle();
        chk("ld_after_ctl", 32'(ctl_a), 32'(C_NONE));
        chk("ld_after_st", 32'(st_a), 0);
        chk("ld_cnt", 32'(cnt_a), 1);
        tick();
        ex_mem_read = 1; ex_rd = 4'd0; id_rs = 4'd0; settle();
        chk("rd0_ctl", 32'(ctl_a), 32'(C_NONE));
        tick();
        ex_mem_read = 1; ex_rd = 4'd3; id_rs = 4'd5; id_rt = 4'd3; id_uses_rt = 0; settle();
        chk("rt_unused", 32'(ctl_a), 32'(C_NONE));
        id_uses_rt = 1; settle();
        chk("rt_used", 32'(ctl_a), 32'(C_STALL));
        tick(); idle(); settle();
        chk("rt_cnt", 32'(cnt_a), 2);

        // 3. branch flush (A)
        do_reset();
        branch_taken = 1; settle();
        chk("br_ctl0", 32'(ctl_a), 32'(C_FLUSH));
        chk("br_st0", 32'(st_a), 0);
        tick(); branch_taken = 0; settle();
        chk("br_ctl1", 32'(ctl_a), 32'(C_FLUSH));
        chk("br_st1", 32'(st_a), 2);
        tick(); settle();
        chk("br_ctl2", 32'(ctl_a), 32'(C_NONE));
        chk("br_st2", 32'(st_a), 0);
        chk("br_cnt", 32'(cnt_a), 0);

        // 4. two-cycle stall interrupted by a freeze (B)
        do_reset();
        set_hazard(); settle();
        chk("fz_ctl0", 32'(ctl_b), 32'(C_STALL));
        tick(); idle(); mem_busy = 1; settle();
        chk("fz_ctl1", 32'(ctl_b), 32'(C_FRZ));
        chk("fz_st1", 32'(st_b), 1);
        tick(); settle();
        chk("fz_ctl2", 32'(ctl_b), 32'(C_FRZ));
        chk("fz_st2", 32'(st_b), 3);
        tick(); settle();
        chk("fz_ctl3", 32'(ctl_b), 32'(C_FRZ));
        tick(); mem_busy = 0; settle();
        chk("fz_resume_ctl", 32'(ctl_b), 32'(C_STALL));
        chk("fz_resume_st", 32'(st_b), 3);
        tick(); settle();
        chk("fz_end_ctl", 32'(ctl_b), 32'(C_NONE));
        chk("fz_end_st", 32'(st_b), 0);
        chk("fz_cnt", 32'(cnt_b), 5);

        // 5. branch beats hazard in RUN (A), and in LD_STALL (B)
        do_reset();
        set_hazard(); branch_taken = 1; settle();
        chk("brhz_ctl", 32'(ctl_a), 32'(C_FLUSH));
        tick(); idle(); settle();
        chk("brhz_st", 32'(st_a), 2);
        chk("brhz_ctl1", 32'(ctl_a), 32'(C_FLUSH));
        do_reset();
        set_hazard(); settle();
        tick(); idle(); branch_taken = 1; settle();
        chk("ldbr_st", 32'(st_b), 1);
        chk("ldbr_ctl", 32'(ctl_b), 32'(C_FLUSH));
        tick(); branch_taken = 0; settle();
        chk("ldbr_st1", 32'(st_b), 2);
        chk("ldbr_cnt", 32'(cnt_b), 1);

        // 6. counter saturation, then reset out of MEM_WAIT
        do_reset();
        mem_busy = 1;
        repeat (70000) tick();
        settle();
        chk("sat_cnt", 32'(cnt_a), 32'hFFFF);
        chk("sat_st", 32'(st_a), 3);
        tick(); settle();
        chk("sat_hold", 32'(cnt_a), 32'hFFFF);
        reset = 1; settle();
        chk("mw_rst_ctl", 32'(ctl_a), 32'(C_RST));
        tick(); reset = 0; mem_busy = 0; settle();
        chk("mw_rst_st", 32'(st_a), 0);
        chk("mw_rst_cnt", 32'(cnt_a), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
